// File: rtl/icache_sa.sv
// Two-way set-associative I-cache with line refill, LRU and flush.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module icache_sa #(
  parameter int ADDR_WIDTH      = 17,
  parameter int SET_WIDTH       = 6,
  parameter int LINE_WORD_WIDTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        iu_to_ic_valid,
  input  logic [31:0] iu_to_ic_pc,
  output logic        ic_to_iu_ready,
  output logic [31:0] ic_to_iu_inst,
  output logic        ic_to_mc_request,
  output logic [31:0] ic_to_mc_addr,
  input  logic        mc_to_ic_ready,
  input  logic [31:0] mc_to_ic_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LW    = LINE_WORD_WIDTH;
  localparam int TW    = ADDR_WIDTH - SET_WIDTH - LW - 2;
  localparam int SETS  = 1 << SET_WIDTH;
  localparam int WORDS = 1 << LW;
  localparam int OB    = LW + 2;

  localparam logic IDLE   = 1'b0;
  localparam logic REFILL = 1'b1;

  logic [SET_WIDTH-1:0] idx;
  logic [LW-1:0]        off;
  logic [TW-1:0]        tag;

  assign idx = iu_to_ic_pc[SET_WIDTH+OB-1 -: SET_WIDTH];
  assign off = iu_to_ic_pc[OB-1 -: LW];
  assign tag = iu_to_ic_pc[ADDR_WIDTH-1 -: TW];

  logic unused_pc;
  assign unused_pc = ^iu_to_ic_pc[1:0];

  logic [SETS-1:0] valid0, valid1, lru;
  logic [TW-1:0]   tag0 [SETS];
  logic [TW-1:0]   tag1 [SETS];
  logic [31:0]     data0 [SETS*WORDS];
  logic [31:0]     data1 [SETS*WORDS];

  logic                 state;
  logic [LW-1:0]        cnt;
  logic [LW-1:0]        cnt_inc;
  logic                 victim;
  logic                 victim_nxt;
  logic                 discard;
  logic [SET_WIDTH-1:0] fill_idx;
  logic [TW-1:0]        fill_tag;

  logic hit0, hit1, hit;
  logic fill, done, start;

  assign hit0 = iu_to_ic_valid && valid0[idx]
             && (tag0[idx] == tag);
  assign hit1 = iu_to_ic_valid && valid1[idx]
             && (tag1[idx] == tag);
  assign hit  = hit0 | hit1;

  assign ic_to_iu_ready = hit;

  always_comb begin
    ic_to_iu_inst = '0;
    unique case (1'b1)
      hit0:    ic_to_iu_inst = data0[{idx, off}];
      hit1:    ic_to_iu_inst = data1[{idx, off}];
      default: ic_to_iu_inst = '0;
    endcase
  end

  assign cnt_inc = cnt + 1'b1;
  assign fill  = rdy_in && (state == REFILL)
              && mc_to_ic_ready;
  assign done  = fill && (cnt == {LW{1'b1}});
  assign start = rdy_in && (state == IDLE)
              && !flush_in && iu_to_ic_valid && !hit;

  // Fill invalid ways first; only evict by LRU when the set is full.
  assign victim_nxt = !valid0[idx] ? 1'b0 :
                      !valid1[idx] ? 1'b1 : lru[idx];

  always_ff @(posedge clk_in) begin
    if (fill) begin
      if (victim) data1[{fill_idx, cnt}] <= mc_to_ic_data;
      else        data0[{fill_idx, cnt}] <= mc_to_ic_data;
    end
    if (done) begin
      if (victim) tag1[fill_idx] <= fill_tag;
      else        tag0[fill_idx] <= fill_tag;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid0           <= '0;
      valid1           <= '0;
      lru              <= '0;
      state            <= IDLE;
      cnt              <= '0;
      victim           <= 1'b0;
      discard          <= 1'b0;
      fill_idx         <= '0;
      fill_tag         <= '0;
      ic_to_mc_request <= 1'b0;
      ic_to_mc_addr    <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        valid0 <= '0;
        valid1 <= '0;
      end
      unique case (1'b1)
        (state == IDLE): begin
          if (hit) lru[idx] <= hit0;
          if (start) begin
            state            <= REFILL;
            ic_to_mc_request <= 1'b1;
            ic_to_mc_addr    <= {iu_to_ic_pc[31:OB],
                                 {OB{1'b0}}};
            cnt              <= '0;
            victim           <= victim_nxt;
            fill_idx         <= idx;
            fill_tag         <= tag;
            discard          <= 1'b0;
          end
        end
        (state == REFILL): begin
          if (flush_in) discard <= 1'b1;
          if (mc_to_ic_ready) begin
            cnt           <= cnt_inc;
            ic_to_mc_addr <= {ic_to_mc_addr[31:OB],
                              cnt_inc, 2'b00};
            if (cnt == {LW{1'b1}}) begin
              state            <= IDLE;
              ic_to_mc_request <= 1'b0;
              discard          <= 1'b0;
              lru[fill_idx]    <= ~victim;
              if (!discard && !flush_in) begin
                if (victim) valid1[fill_idx] <= 1'b1;
                else        valid0[fill_idx] <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy_in) begin
      if (hit)   hit_cnt  <= hit_cnt + 32'd1;
      if (start) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench for icache_sa: lookup and MC address queues
// checked by monitor processes, with a 2-cycle-latency MC model.
module tb_icache_sa;

  logic        clk_in;
  logic        rst_n_in;
  logic        rdy_in;
  logic        flush_in;
  logic        iu_to_ic_valid;
  logic [31:0] iu_to_ic_pc;
  logic        ic_to_iu_ready;
  logic [31:0] ic_to_iu_inst;
  logic        ic_to_mc_request;
  logic [31:0] ic_to_mc_addr;
  logic        mc_to_ic_ready;
  logic [31:0] mc_to_ic_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_sa dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .rdy_in           (rdy_in),
    .flush_in         (flush_in),
    .iu_to_ic_valid   (iu_to_ic_valid),
    .iu_to_ic_pc      (iu_to_ic_pc),
    .ic_to_iu_ready   (ic_to_iu_ready),
    .ic_to_iu_inst    (ic_to_iu_inst),
    .ic_to_mc_request (ic_to_mc_request),
    .ic_to_mc_addr    (ic_to_mc_addr),
    .mc_to_ic_ready   (mc_to_ic_ready),
    .mc_to_ic_data    (mc_to_ic_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rdy;
    logic [31:0] inst;
    string       nm;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] aq [$];
  int          checks   = 0;
  int          failures = 0;
  logic        chk = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Lookup monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (chk) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL lookup_no_expect actual=%h required=none",
                   ic_to_iu_inst);
        end else begin
          e = exp_q.pop_front();
          check({e.nm, "_rdy"}, {31'd0, ic_to_iu_ready},
                {31'd0, e.rdy});
          check({e.nm, "_inst"}, ic_to_iu_inst, e.inst);
        end
      end
    end
  end

  // MC model: answers 2 cycles after each request; while rdy_in is low
  // it pulses junk every cycle, which the cache must ignore.
  initial begin
    int wt = 0;
    mc_to_ic_ready = 1'b0;
    mc_to_ic_data  = '0;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        mc_to_ic_ready = 1'b0;
        wt = 0;
      end else if (ic_to_mc_request && !rdy_in) begin
        mc_to_ic_ready = 1'b1;
        mc_to_ic_data  = 32'hDEAD_BEEF;
        wt = 0;
      end else if (mc_to_ic_ready) begin
        mc_to_ic_ready = 1'b0;
        wt = 0;
      end else if (ic_to_mc_request) begin
        wt++;
        if (wt == 2) begin
          mc_to_ic_ready = 1'b1;
          mc_to_ic_data  = mem(ic_to_mc_addr);
          wt = 0;
          if (aq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mc_addr actual=%h required=none",
                     ic_to_mc_addr);
          end else begin
            check("mc_addr", ic_to_mc_addr, aq.pop_front());
          end
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input logic h,
                       input string nm);
    iu_to_ic_valid = 1'b1;
    iu_to_ic_pc    = pc;
    exp_q.push_back('{h, h ? mem(pc) : 32'd0, nm});
    chk = 1'b1;
    @(posedge clk_in); #1;
    iu_to_ic_valid = 1'b0;
    chk = 1'b0;
  endtask

  task automatic start_miss(input logic [31:0] pc, input string nm);
    for (int i = 0; i < 4; i++)
      aq.push_back({pc[31:4], 4'h0} + 32'(4 * i));
    fetch(pc, 1'b0, nm);
  endtask

  task automatic wait_refill();
    int n = 0;
    while (ic_to_mc_request && n < 200) begin
      @(posedge clk_in); #1;
      n++;
    end
    check("refill_done", {31'd0, ic_to_mc_request}, 32'd0);
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int n = 0;
    while (ic_to_mc_addr !== a && n < 200) begin
      @(posedge clk_in); #1;
      n++;
    end
    check("reach_addr", ic_to_mc_addr, a);
  endtask

  task automatic miss(input logic [31:0] pc, input string nm);
    start_miss(pc, nm);
    wait_refill();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in       = 1'b0;
    rdy_in         = 1'b1;
    flush_in       = 1'b0;
    iu_to_ic_valid = 1'b1;
    iu_to_ic_pc    = 32'h100;
    #1;
    check("rst_iu_ready", {31'd0, ic_to_iu_ready}, 32'd0);
    check("rst_iu_inst", ic_to_iu_inst, 32'd0);
    check("rst_mc_req", {31'd0, ic_to_mc_request}, 32'd0);
    check("rst_mc_addr", ic_to_mc_addr, 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
    iu_to_ic_valid = 1'b0;
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // cold miss, then same line hits without a new request
    miss(32'h100, "cold_miss");
    fetch(32'h10C, 1'b1, "hit_10c");
    fetch(32'h100, 1'b1, "hit_100");
    check("no_new_req", {31'd0, ic_to_mc_request}, 32'd0);

    // LRU: 0x000 re-hit protects it, 0x800 then 0x400 evictions
    miss(32'h000, "miss_000");
    miss(32'h400, "miss_400");
    fetch(32'h004, 1'b1, "rehit_000");
    miss(32'h800, "miss_800");
    fetch(32'h000, 1'b1, "keep_000");
    fetch(32'h808, 1'b1, "hit_800");
    fetch(32'h000, 1'b1, "rehit2_000");
    miss(32'h404, "evicted_400");
    fetch(32'h408, 1'b1, "refill_400");
    fetch(32'h00C, 1'b1, "still_000");

    // flush during word 2 of a refill
    start_miss(32'h200, "miss_200");
    fetch(32'h104, 1'b1, "hit_in_refill");
    wait_addr(32'h208);
    flush_in = 1'b1;
    @(posedge clk_in); #1;
    flush_in = 1'b0;
    wait_refill();
    start_miss(32'h200, "flushed_200");
    fetch(32'h100, 1'b0, "flushed_100");
    fetch(32'h000, 1'b0, "flushed_000");
    wait_refill();
    fetch(32'h200, 1'b1, "hit_200");
    fetch(32'h20C, 1'b1, "hit_20c");

    // rdy_in low for 3 cycles mid-refill
    start_miss(32'h300, "miss_300");
    wait_addr(32'h304);
    rdy_in = 1'b0;
    repeat (3) begin
      @(posedge clk_in); #1;
    end
    check("stall_addr", ic_to_mc_addr, 32'h304);
    check("stall_req", {31'd0, ic_to_mc_request}, 32'd1);
    rdy_in = 1'b1;
    wait_refill();
    for (int i = 0; i < 4; i++)
      fetch(32'h300 + 32'(4 * i), 1'b1, "stall_word");

    // asynchronous reset mid-refill
    start_miss(32'h500, "miss_500");
    repeat (3) @(posedge clk_in);
    #3;
    rst_n_in = 1'b0;
    #1;
    check("arst_req", {31'd0, ic_to_mc_request}, 32'd0);
    check("arst_addr", ic_to_mc_addr, 32'd0);
    aq.delete();
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    miss(32'h500, "post_rst_500");
    fetch(32'h500, 1'b1, "s1");
    fetch(32'h504, 1'b1, "s2");
    fetch(32'h508, 1'b1, "s3");
    fetch(32'h50C, 1'b1, "s4");
    fetch(32'h500, 1'b1, "s5");
    fetch(32'h504, 1'b1, "s6");
    fetch(32'h508, 1'b1, "s7");
`ifdef ICACHE_STATS_EN
    check("miss_cnt", miss_cnt, 32'd1);
    check("hit_cnt", hit_cnt, 32'd7);
`endif

    repeat (3) @(posedge clk_in);
    #1;
    check("lookup_q_left", 32'(exp_q.size()), 32'd0);
    check("mc_q_left", 32'(aq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
